// File: rtl/gpu_video_pkg.sv
// Shared timing defaults and flag types for the raster scan path.
// The defaults describe 800x600 scanned out of a 200x150 framebuffer.
package gpu_video_pkg;

    typedef struct packed {
        logic [15:0] h_vis;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_vis;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } scan_timing_t;

    localparam scan_timing_t DEF_TIMING = '{
        h_vis: 16'd200, h_fp: 16'd10, h_sync: 16'd32, h_bp: 16'd22,
        v_vis: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,  v_bp: 16'd23
    };

    localparam int DEF_X_SHIFT = 0;
    localparam int DEF_Y_SHIFT = 2;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
        logic fs;
    } scan_flags_t;

    // Number of framebuffer cells needed to cover n pixels after a >> s downscale.
    function automatic int scaled_extent(input int n, input int s);
        return (n + (1 << s) - 1) >> s;
    endfunction

endpackage

// File: rtl/video_flag_delay.sv
// Enabled shift register for the sync/enable flag bundle; matches framebuffer read latency.
// DEPTH=0 degenerates to a straight wire.
module video_flag_delay
    import gpu_video_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  scan_flags_t d,
    output scan_flags_t q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_shift
            scan_flags_t stage_reg [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
                end else if (en) begin
                    stage_reg[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
                end
            end

            assign q = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_scan_ctrl.sv
// Raster scan controller: h/v counters, flag decode, scaled framebuffer address,
// and sync/DE/frame-start outputs delayed to line up with returned pixel data.
module video_scan_ctrl
    import gpu_video_pkg::*;
#(
    parameter int H_VIS       = int'(DEF_TIMING.h_vis),
    parameter int H_FP        = int'(DEF_TIMING.h_fp),
    parameter int H_SYNC      = int'(DEF_TIMING.h_sync),
    parameter int H_BP        = int'(DEF_TIMING.h_bp),
    parameter int V_VIS       = int'(DEF_TIMING.v_vis),
    parameter int V_FP        = int'(DEF_TIMING.v_fp),
    parameter int V_SYNC      = int'(DEF_TIMING.v_sync),
    parameter int V_BP        = int'(DEF_TIMING.v_bp),
    parameter bit HSYNC_POL   = 1'b1,
    parameter bit VSYNC_POL   = 1'b1,
    parameter int X_SHIFT     = DEF_X_SHIFT,
    parameter int Y_SHIFT     = DEF_Y_SHIFT,
    parameter int ADDR_X_BITS = 8,
    parameter int ADDR_Y_BITS = 8,
    parameter int PIPE_DELAY  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pix_ce,
    output logic [ADDR_Y_BITS+ADDR_X_BITS-1:0] addr,
    output logic                               oe,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               de,
    output logic                               frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = ADDR_Y_BITS + ADDR_X_BITS;

    if (scaled_extent(H_VIS, X_SHIFT) > (1 << ADDR_X_BITS)) begin : g_bad_x
        $error("video_scan_ctrl: visible columns do not fit in ADDR_X_BITS");
    end
    if (scaled_extent(V_VIS, Y_SHIFT) > (1 << ADDR_Y_BITS)) begin : g_bad_y
        $error("video_scan_ctrl: visible rows do not fit in ADDR_Y_BITS");
    end

    logic [HW-1:0]          h_reg, h_next;
    logic [VW-1:0]          v_reg, v_next;
    logic [AW-1:0]          addr_reg;
    logic                   oe_reg;
    scan_flags_t            flags, flags_reg, flags_d;
    logic [ADDR_Y_BITS-1:0] row;
    logic [ADDR_X_BITS-1:0] col;

    always_comb begin
        h_next = h_reg + 1'b1;
        v_next = v_reg;
        if (h_reg == HW'(H_TOTAL - 1)) begin
            h_next = '0;
            v_next = (v_reg == VW'(V_TOTAL - 1)) ? '0 : v_reg + 1'b1;
        end
    end

    // Integer compares keep the decode correct when a window ends exactly at 2**HW.
    always_comb begin
        flags.vis = (int'(h_reg) < H_VIS) && (int'(v_reg) < V_VIS);
        flags.hs  = (int'(h_reg) >= H_VIS + H_FP) && (int'(h_reg) < H_VIS + H_FP + H_SYNC);
        flags.vs  = (int'(v_reg) >= V_VIS + V_FP) && (int'(v_reg) < V_VIS + V_FP + V_SYNC);
        flags.fs  = (h_reg == '0) && (v_reg == '0);
    end

    assign row = ADDR_Y_BITS'(v_reg >> Y_SHIFT);
    assign col = ADDR_X_BITS'(h_reg >> X_SHIFT);

    // Address stage; flags are registered here too so no output is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg     <= '0;
            v_reg     <= '0;
            addr_reg  <= '0;
            oe_reg    <= 1'b0;
            flags_reg <= '0;
        end else if (pix_ce) begin
            h_reg     <= h_next;
            v_reg     <= v_next;
            addr_reg  <= flags.vis ? {row, col} : '0;
            oe_reg    <= flags.vis;
            flags_reg <= flags;
        end
    end

    video_flag_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_flag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_ce),
        .d     (flags_reg),
        .q     (flags_d)
    );

    assign addr        = addr_reg;
    assign oe          = oe_reg;
    assign hsync       = flags_d.hs ? HSYNC_POL : ~HSYNC_POL;
    assign vsync       = flags_d.vs ? VSYNC_POL : ~VSYNC_POL;
    assign de          = flags_d.vis;
    assign frame_start = flags_d.fs;

endmodule

// File: doc/video_scan_ctrl.md
# video_scan_ctrl

Parametrised raster scan controller for the GPU video path. It generates horizontal and vertical timing and a scaled framebuffer read address with its output enable. HSYNC, VSYNC, DE and FRAME_START are delayed to line up with pixel data returned by a framebuffer of configurable read latency. It replaces the fixed 200×150 (800×600/4) counter/sync-generator chain and sits between the pixel clock domain and the framebuffer RAM.

## Interface
Parameters:
- H_VIS, 200: visible pixels per line
- H_FP, 10: horizontal front porch
- H_SYNC, 32: horizontal sync width
- H_BP, 22: horizontal back porch
- V_VIS, 600: visible lines per frame
- V_FP, 1: vertical front porch
- V_SYNC, 4: vertical sync width
- V_BP, 23: vertical back porch
- HSYNC_POL, 1: active level of HSYNC
- VSYNC_POL, 1: active level of VSYNC
- X_SHIFT, 0: horizontal downscale (column >> X_SHIFT)
- Y_SHIFT, 2: vertical downscale (line >> Y_SHIFT)
- ADDR_X_BITS, 8: column field width in ADDR
- ADDR_Y_BITS, 8: row field width in ADDR
- PIPE_DELAY, 1: framebuffer read latency in enabled cycles (0 is legal)

Ports:
- CLK  in  1  pixel clock
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- PIX_CE  in  1  pixel clock enable; all state advances only when high
- ADDR  out  ADDR_Y_BITS+ADDR_X_BITS  framebuffer address {row, col}
- OE  out  1  framebuffer read enable (active-high)
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- DE  out  1  display enable, aligned with returned pixel data
- FRAME_START  out  1  one-cycle pulse on the first pixel of each frame, aligned with DE

## Operation
- Derived values: H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP (264) and V_TOTAL (628). Counter widths are $clog2 of each total.
- Elaboration error if ceil(H_VIS/2^X_SHIFT) > 2^ADDR_X_BITS, or if the same check fails for the vertical dimension.
- h counts 0..H_TOTAL-1 and wraps to 0. v increments on each h wrap and wraps from V_TOTAL-1 to 0. The counters update only when PIX_CE=1.
- Stage-0 flags are decoded from (h,v):
  - vis = (h<H_VIS) & (v<V_VIS)
  - hs = h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC)
  - vs = v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC)
  - fs = (h==0) & (v==0)
- Address stage (registered): OE <= vis. ADDR <= vis ? {v>>Y_SHIFT, h>>X_SHIFT} : 0, with each field truncated to its width.
- Sync stage: {hs, vs, vis, fs} pass through a PIPE_DELAY-deep delay after the address stage.
  - HSYNC = hs_d ? HSYNC_POL : ~HSYNC_POL. VSYNC is formed the same way.
  - DE = vis_d. FRAME_START = fs_d.
- When PIX_CE=0, counters, the address register and the delay line all hold.

## Timing
- Reset values: h=v=0, ADDR=0, OE=0, DE=0, FRAME_START=0, HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL. The delay line is cleared to inactive.
- Latency, counted in enabled cycles after the counters sit at (h,v):
  - ADDR and OE for that position are valid 1 cycle later.
  - HSYNC, VSYNC, DE and FRAME_START for that position are valid 1+PIPE_DELAY cycles later.
- First enabled edge after reset release: ADDR=0 and OE=1 (pixel 0,0). FRAME_START pulses PIPE_DELAY cycles later, so the first frame is flagged.
- Frame wrap: (H_TOTAL-1, V_TOTAL-1) is followed by (0,0) with no idle cycle. FRAME_START is high for exactly one enabled cycle per frame.
- PIX_CE gating: an output that is high when PIX_CE drops stays high until the next enabled cycle. The pulse width of FRAME_START is therefore one enabled cycle.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for a clock. Scanning restarts at (0,0).
- All outputs are registered; no combinational path exists from PIX_CE to any output.

## Structure
- Package gpu_video_pkg holds:
  - default timing constants for 800×600/4
  - a timing-parameter struct typedef
  - a flag bundle typedef {hs, vs, vis, fs}
- One sub-module, video_flag_delay: a PIPE_DELAY-deep shift register of the flag bundle, with enable and asynchronous clear. It must collapse to wires when PIPE_DELAY=0.
- Counters, decode and the address register stay in video_scan_ctrl.

## Test plan
- Reset, then PIX_CE=1 held (defaults) -> cycle 1: ADDR=0x0000, OE=1; cycle 2: DE=1, FRAME_START=1; cycle 3: FRAME_START=0.
- Run one line -> OE high for exactly 200 cycles per line. HSYNC is high for 32 cycles, starting 211+PIPE_DELAY cycles after the line starts. Line period is 264.
- Run two frames -> FRAME_START period = 165792 cycles. VSYNC is high for 4 lines, starting at line 601. DE is never high when line ≥ 600.
- Scaling check: counters at (h=199, v=599) -> ADDR=0x95C7 (row 149, col 199). Counters at (h=3, v=7) -> ADDR=0x0103.
- PIX_CE toggled 1-of-4 -> the sequence of enabled-cycle outputs is identical to the PIX_CE=1 run. Outputs are stable during disabled cycles.
- RST_N pulsed low at (h=100, v=300); PIPE_DELAY=0 variant included -> outputs return to reset values asynchronously. After release, FRAME_START follows the first enabled cycle after 1+PIPE_DELAY cycles.
